// File: rtl/graphics_sprite_animator.sv
// Pipelined 1-bpp sprite renderer: maps the VGA scan position onto a rotated sprite
// and sequences the chomp (ping-pong) and death animations; bitmaps come from an external row ROM.
module graphics_sprite_animator #(
  parameter int          SPRITE_SIZE  = 15,
  parameter int          NUM_FRAMES   = 3,
  parameter int          DEATH_FRAMES = 8,
  parameter int          FRAME_TICKS  = 4,
  parameter logic [7:0]  COLOR        = 8'hFC,
  localparam int         FW = $clog2(NUM_FRAMES + DEATH_FRAMES),
  localparam int         RW = $clog2(SPRITE_SIZE)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   frame_tick_i,
  input  logic [8:0]             xpos_i,
  input  logic [8:0]             ypos_i,
  input  logic [8:0]             xloc_i,
  input  logic [8:0]             yloc_i,
  input  logic [1:0]             dir_i,
  input  logic                   alive_i,
  input  logic                   moving_i,
  output logic [FW-1:0]          rom_frame_o,
  output logic [RW-1:0]          rom_row_o,
  input  logic [SPRITE_SIZE-1:0] rom_bits_i,
  output logic                   pixel_on_o,
  output logic [7:0]             color_o
);

  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [TW-1:0]       TICK_LAST   = TW'(FRAME_TICKS - 1);
  localparam logic [FW-1:0]       LAST_ALIVE  = FW'(NUM_FRAMES - 1);
  localparam logic [FW-1:0]       FIRST_DEATH = FW'(NUM_FRAMES);
  localparam logic [FW-1:0]       LAST_DEATH  = FW'(NUM_FRAMES + DEATH_FRAMES - 1);
  localparam logic [RW-1:0]       SMAX        = RW'(SPRITE_SIZE - 1);
  localparam logic [8:0]          SMAX9       = 9'(SPRITE_SIZE - 1);
  localparam logic signed [9:0]   COFF        = 10'((SPRITE_SIZE - 1) / 2);

  typedef enum logic [1:0] {ALIVE, DYING, DEAD} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            up_q, up_d;
  logic            step;

  logic signed [9:0] dx, dy;
  logic [RW-1:0]     dxr, dyr, row, col;
  logic [1:0]        dir_eff;
  logic              in_box;

  logic [FW-1:0]   rom_frame_q;
  logic [RW-1:0]   rom_row_q;
  logic [RW-1:0]   col_q;
  logic            in_box_q, dead_q;
  logic            pixel_q, pixel_d;
  logic [7:0]      color_q;
  logic            bit_sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ALIVE;
      tick_q  <= '0;
      frame_q <= '0;
      up_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      up_q    <= up_d;
    end
  end

  // Alive/dead changes take priority and swallow any coincident frame tick.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    frame_d = frame_q;
    up_d    = up_q;
    step    = frame_tick_i && (tick_q == TICK_LAST);
    if (state_q == ALIVE && !alive_i) begin
      state_d = DYING;
      frame_d = FIRST_DEATH;
      tick_d  = '0;
    end else if (state_q != ALIVE && alive_i) begin
      state_d = ALIVE;
      frame_d = '0;
      tick_d  = '0;
      up_d    = 1'b1;
    end else if (frame_tick_i) begin
      case (state_q)
        ALIVE: begin
          if (moving_i) begin
            tick_d = step ? '0 : tick_q + 1'b1;
            if (step) begin
              if (up_q) begin
                if (frame_q == LAST_ALIVE) begin
                  if (NUM_FRAMES > 1) begin
                    frame_d = frame_q - 1'b1;
                    up_d    = 1'b0;
                  end
                end else begin
                  frame_d = frame_q + 1'b1;
                end
              end else if (frame_q == '0) begin
                frame_d = FW'(1);
                up_d    = 1'b1;
              end else begin
                frame_d = frame_q - 1'b1;
              end
            end
          end
        end
        DYING: begin
          tick_d = step ? '0 : tick_q + 1'b1;
          if (step) begin
            if (frame_q == LAST_DEATH) state_d = DEAD;
            else                       frame_d = frame_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage 0: offsets are 10-bit signed so sprites near the screen origin never wrap into the box.
  always_comb begin
    dx      = $signed({1'b0, xpos_i}) - $signed({1'b0, xloc_i}) + COFF;
    dy      = $signed({1'b0, ypos_i}) - $signed({1'b0, yloc_i}) + COFF;
    in_box  = !dx[9] && (dx[8:0] <= SMAX9) && !dy[9] && (dy[8:0] <= SMAX9);
    dxr     = dx[RW-1:0];
    dyr     = dy[RW-1:0];
    dir_eff = (state_q == DYING) ? 2'b00 : dir_i;
    row     = dyr;
    col     = dxr;
    case (dir_eff)
      2'b01:   begin row = dxr;        col = SMAX - dyr; end
      2'b10:   begin row = SMAX - dxr; col = dyr;        end
      2'b11:   begin row = SMAX - dyr; col = SMAX - dxr; end
      default: begin row = dyr;        col = dxr;        end
    endcase
  end

  always_comb begin
    bit_sel = in_box_q ? rom_bits_i[SMAX - col_q] : 1'b0;
    pixel_d = in_box_q & ~dead_q & bit_sel;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rom_frame_q <= '0;
      rom_row_q   <= '0;
      col_q       <= '0;
      in_box_q    <= 1'b0;
      dead_q      <= 1'b0;
      pixel_q     <= 1'b0;
      color_q     <= 8'h00;
    end else begin
      rom_frame_q <= frame_q;
      rom_row_q   <= row;
      col_q       <= col;
      in_box_q    <= in_box;
      dead_q      <= (state_q == DEAD);
      pixel_q     <= pixel_d;
      color_q     <= pixel_d ? COLOR : 8'h00;
    end
  end

  assign rom_frame_o = rom_frame_q;
  assign rom_row_o   = rom_row_q;
  assign pixel_on_o  = pixel_q;
  assign color_o     = color_q;

endmodule

// File: tb/tb_graphics_sprite_animator.sv
// Self-checking bench for graphics_sprite_animator: a tick-counting animation model and
// a geometric pixel model are compared against the DUT every cycle, plus literal spot checks.
module tb_graphics_sprite_animator;

  localparam int SS    = 15;
  localparam int NF    = 3;
  localparam int DF    = 8;
  localparam int FT    = 4;
  localparam int C     = (SS - 1) / 2;
  localparam int S     = SS - 1;
  localparam int NROM  = NF + DF;
  localparam int LASTF = NF + DF - 1;
  localparam logic [7:0] COLOR = 8'hFC;

  logic          clock = 1'b0;
  logic          reset, frameTick, alive, moving;
  logic [8:0]    xpos, ypos, xloc, yloc;
  logic [1:0]    dir;
  logic [3:0]    romFrame, romRow;
  logic [SS-1:0] romBits;
  logic          pixelOn;
  logic [7:0]    color;

  logic [SS-1:0] rom [NROM][SS];

  int checks = 0;
  int errors = 0;

  // Model state: animation progress is kept as raw tick counts since the last alive change.
  bit dyingMode;
  int aliveTicks, deathTicks;

  typedef struct {
    bit rst;
    bit inBox;
    bit dead;
    int row;
    int col;
    int frame;
  } entry_t;

  entry_t curE, prevE;

  always #5 clock = ~clock;

  always_comb begin
    romBits = '0;
    if (int'(romFrame) < NROM && int'(romRow) < SS) romBits = rom[int'(romFrame)][int'(romRow)];
  end

  graphics_sprite_animator #(
    .SPRITE_SIZE(SS), .NUM_FRAMES(NF), .DEATH_FRAMES(DF), .FRAME_TICKS(FT), .COLOR(COLOR)
  ) dut (
    .clk_i(clock), .rst_i(reset), .frame_tick_i(frameTick),
    .xpos_i(xpos), .ypos_i(ypos), .xloc_i(xloc), .yloc_i(yloc),
    .dir_i(dir), .alive_i(alive), .moving_i(moving),
    .rom_frame_o(romFrame), .rom_row_o(romRow), .rom_bits_i(romBits),
    .pixel_on_o(pixelOn), .color_o(color)
  );

  function automatic int fold(int k);
    int p, m;
    if (NF == 1) return 0;
    p = 2 * NF - 2;
    m = k % p;
    return (m < NF) ? m : p - m;
  endfunction

  function automatic bit modelDead();
    return dyingMode && (deathTicks >= DF * FT);
  endfunction

  function automatic int modelFrame();
    int f;
    if (!dyingMode) return fold(aliveTicks / FT);
    f = NF + deathTicks / FT;
    return (f > LASTF) ? LASTF : f;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    bit expPix;
    expPix = 1'b0;
    if (!curE.rst && prevE.inBox && !prevE.dead) expPix = rom[prevE.frame][prevE.row][S - prevE.col];
    check("pixel_on", 32'(pixelOn), 32'(expPix));
    check("color", 32'(color), expPix ? 32'(COLOR) : 32'h0);
    check("rom_frame", 32'(romFrame), 32'(curE.frame));
    if (curE.rst || curE.inBox) check("rom_row", 32'(romRow), 32'(curE.row));
  endtask

  // One clock: derive the expected pipeline entry from the current inputs, advance the model, then compare.
  task automatic applyStimulus();
    entry_t e;
    int dx, dy, d;
    dx = int'(xpos) - int'(xloc) + C;
    dy = int'(ypos) - int'(yloc) + C;
    e.rst   = reset;
    e.dead  = modelDead();
    e.inBox = !reset && dx >= 0 && dx <= S && dy >= 0 && dy <= S;
    e.frame = reset ? 0 : modelFrame();
    d = (dyingMode && !e.dead) ? 0 : int'(dir);
    case (d)
      1:       begin e.row = dx;     e.col = S - dy; end
      2:       begin e.row = S - dx; e.col = dy;     end
      3:       begin e.row = S - dy; e.col = S - dx; end
      default: begin e.row = dy;     e.col = dx;     end
    endcase
    if (reset) begin
      e.row = 0;
      e.col = 0;
    end
    if (reset) begin
      dyingMode = 0; aliveTicks = 0; deathTicks = 0;
    end else if (!dyingMode && !alive) begin
      dyingMode = 1; deathTicks = 0;
    end else if (dyingMode && alive) begin
      dyingMode = 0; aliveTicks = 0;
    end else if (frameTick) begin
      if (!dyingMode && moving) aliveTicks++;
      else if (dyingMode && deathTicks < DF * FT) deathTicks++;
    end
    @(posedge clock);
    #1;
    prevE = curE;
    curE  = e;
    checkOutput();
  endtask

  task automatic tickPair();
    frameTick = 1'b1;
    applyStimulus();
    frameTick = 1'b0;
    applyStimulus();
  endtask

  task automatic scanAt(input int x, input int y);
    xpos = 9'(x);
    ypos = 9'(y);
    applyStimulus();
  endtask

  // kind 0: filled disc, 1: all set, 2: only row 0 column SS-1, 3: random
  task automatic loadRom(input int kind);
    for (int f = 0; f < NROM; f++)
      for (int r = 0; r < SS; r++)
        for (int c = 0; c < SS; c++)
          case (kind)
            0:       rom[f][r][S - c] = ((r - C) * (r - C) + (c - C) * (c - C)) <= C * C;
            1:       rom[f][r][S - c] = 1'b1;
            2:       rom[f][r][S - c] = (r == 0 && c == S);
            default: rom[f][r][S - c] = 1'($urandom_range(0, 1));
          endcase
  endtask

  initial begin
    int seq [7];
    seq = '{0, 1, 2, 1, 0, 1, 2};
    curE = '{rst: 1'b1, inBox: 1'b0, dead: 1'b0, row: 0, col: 0, frame: 0};
    prevE = curE;
    dyingMode = 0; aliveTicks = 0; deathTicks = 0;
    reset = 1'b1; frameTick = 1'b0; alive = 1'b1; moving = 1'b0; dir = 2'b00;
    xpos = 9'd0; ypos = 9'd0; xloc = 9'd100; yloc = 9'd100;
    loadRom(0);

    applyStimulus();
    applyStimulus();
    check("reset_pixel", 32'(pixelOn), 32'h0);
    check("reset_color", 32'(color), 32'h0);
    check("reset_frame", 32'(romFrame), 32'h0);
    reset = 1'b0;

    scanAt(100, 100);
    scanAt(93, 93);
    check("disc_centre_pixel", 32'(pixelOn), 32'h1);
    check("disc_centre_color", 32'(color), 32'hFC);
    scanAt(108, 100);
    check("disc_corner", 32'(pixelOn), 32'h0);
    applyStimulus();
    check("disc_outside", 32'(pixelOn), 32'h0);

    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    moving = 1'b1;
    applyStimulus();
    check("pingpong_0", 32'(romFrame), 32'(seq[0]));
    for (int k = 1; k < 7; k++) begin
      for (int t = 0; t < FT; t++) begin
        xpos = 9'(100 + $urandom_range(0, 16) - 8);
        ypos = 9'(100 + $urandom_range(0, 16) - 8);
        tickPair();
      end
      check($sformatf("pingpong_%0d", k), 32'(romFrame), 32'(seq[k]));
    end
    moving = 1'b0;
    repeat (8) tickPair();
    check("frozen_frame", 32'(romFrame), 32'd2);
    moving = 1'b1;
    repeat (FT) tickPair();
    check("resume_frame", 32'(romFrame), 32'd1);
    moving = 1'b0;

    loadRom(2);
    for (int d = 0; d < 4; d++) begin
      dir = 2'(d);
      case (d)
        0:       scanAt(100 + C, 100 - C);
        1:       scanAt(100 - C, 100 - C);
        2:       scanAt(100 + C, 100 + C);
        default: scanAt(100 - C, 100 + C);
      endcase
      scanAt(100, 100);
      check($sformatf("rotate_dir%0d", d), 32'(pixelOn), 32'h1);
      applyStimulus();
      check($sformatf("rotate_centre%0d", d), 32'(pixelOn), 32'h0);
    end

    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    loadRom(3);
    xloc = 9'd200; yloc = 9'd200; dir = 2'b11; moving = 1'b1;
    alive = 1'b0; frameTick = 1'b1;
    scanAt(203, 198);
    frameTick = 1'b0;
    applyStimulus();
    check("death_first_frame", 32'(romFrame), 32'd3);
    repeat (3) tickPair();
    check("death_tick_not_counted", 32'(romFrame), 32'd3);
    tickPair();
    check("death_frame4", 32'(romFrame), 32'd4);
    repeat (DF * FT - 4) begin
      xpos = 9'(200 + $urandom_range(0, 16) - 8);
      ypos = 9'(200 + $urandom_range(0, 16) - 8);
      tickPair();
    end
    check("dead_frame", 32'(romFrame), 32'd10);
    loadRom(1);
    scanAt(200, 200);
    applyStimulus();
    check("dead_pixel", 32'(pixelOn), 32'h0);
    repeat (4) tickPair();
    alive = 1'b1;
    applyStimulus();
    applyStimulus();
    check("revive_frame", 32'(romFrame), 32'd0);

    dir = 2'b00; moving = 1'b0;
    xloc = 9'd3; yloc = 9'd2;
    scanAt(0, 0);
    scanAt(511, 0);
    check("origin_in_box", 32'(pixelOn), 32'h1);
    scanAt(10, 0);
    check("wrap_out_of_box", 32'(pixelOn), 32'h0);
    scanAt(11, 0);
    check("right_edge_in_box", 32'(pixelOn), 32'h1);
    applyStimulus();
    check("past_right_edge", 32'(pixelOn), 32'h0);

    xloc = 9'd50; yloc = 9'd60;
    alive = 1'b0;
    scanAt(50, 60);
    repeat (3 * FT) tickPair();
    check("dying_frame6", 32'(romFrame), 32'd6);
    check("dying_pixel", 32'(pixelOn), 32'h1);
    reset = 1'b1; alive = 1'b1;
    applyStimulus();
    check("rst_dying_frame", 32'(romFrame), 32'd0);
    check("rst_dying_pixel", 32'(pixelOn), 32'h0);
    check("rst_dying_color", 32'(color), 32'h0);
    reset = 1'b0;

    loadRom(3);
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 499) == 0);
      frameTick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) alive = ~alive;
      if ($urandom_range(0, 49) == 0) moving = ~moving;
      if ($urandom_range(0, 31) == 0) dir = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        xloc = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 9)) : 9'($urandom_range(0, 511));
        yloc = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 9)) : 9'($urandom_range(0, 511));
      end
      if ($urandom_range(0, 299) == 0) rom[$urandom_range(0, NROM - 1)][$urandom_range(0, SS - 1)] = SS'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        xpos = 9'($urandom_range(0, 511));
        ypos = 9'($urandom_range(0, 511));
      end else begin
        xpos = 9'(int'(xloc) + int'($urandom_range(0, 20)) - 10);
        ypos = 9'(int'(yloc) + int'($urandom_range(0, 20)) - 10);
      end
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
